// File: rtl/doppler_ping_sequencer.sv
// Sonar ping sequencer: TX burst, ring-down blanking, ADC capture gating,
// result wait with timeout, and cooldown with optional continuous re-arm.
module doppler_ping_sequencer #(
    parameter int CLK_FREQ          = 100_000_000,
    parameter int EMITTED_FREQUENCY = 40_000,
    parameter int TX_PULSES         = 8,
    parameter int BLANK_CYCLES      = 50_000,
    parameter int NUM_SAMPLES       = 2048,
    parameter int RESULT_TIMEOUT    = 100_000,
    parameter int COOLDOWN_CYCLES   = 1_000_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        continuous_in,
    input  logic        adc_valid_in,
    input  logic [15:0] adc_data_in,
    output logic        sample_valid_out,
    output logic [15:0] sample_out,
    input  logic        doppler_ready_in,
    input  logic [15:0] velocity_in,
    output logic        tx_out,
    output logic [15:0] velocity_out,
    output logic        velocity_valid_out,
    output logic        timeout_out,
    output logic        busy_out
);

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int HALF   = CLK_FREQ / (2 * EMITTED_FREQUENCY);
    localparam int PHASES = 2 * TX_PULSES;

    localparam int HALF_W  = cw(HALF);
    localparam int PHASE_W = cw(PHASES);
    localparam int BLANK_W = cw(BLANK_CYCLES);
    localparam int SMP_W   = cw(NUM_SAMPLES);
    localparam int WAIT_W  = cw(RESULT_TIMEOUT);
    localparam int COOL_W  = cw(COOLDOWN_CYCLES);

    localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(HALF - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [SMP_W-1:0]   SMP_LAST   = SMP_W'(NUM_SAMPLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(RESULT_TIMEOUT - 1);
    localparam logic [COOL_W-1:0]  COOL_LAST  = COOL_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_BLANK,
        ST_CAPTURE,
        ST_WAIT,
        ST_COOL
    } state_t;

    state_t               state;
    logic [HALF_W-1:0]    half_cnt;
    logic [PHASE_W-1:0]   phase_cnt;
    logic [BLANK_W-1:0]   blank_cnt;
    logic [SMP_W-1:0]     smp_cnt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [COOL_W-1:0]    cool_cnt;
    logic                 tx_q;

    // Drive is cut combinationally so the transducer stops the moment reset rises.
    assign tx_out = tx_q & ~rst_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state              <= ST_IDLE;
            half_cnt           <= '0;
            phase_cnt          <= '0;
            blank_cnt          <= '0;
            smp_cnt            <= '0;
            wait_cnt           <= '0;
            cool_cnt           <= '0;
            tx_q               <= 1'b0;
            busy_out           <= 1'b0;
            sample_valid_out   <= 1'b0;
            sample_out         <= '0;
            velocity_out       <= '0;
            velocity_valid_out <= 1'b0;
            timeout_out        <= 1'b0;
        end else begin
            sample_valid_out   <= 1'b0;
            velocity_valid_out <= 1'b0;
            timeout_out        <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        state    <= ST_TX;
                        tx_q     <= 1'b1;
                        busy_out <= 1'b1;
                    end
                end

                ST_TX: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        if (phase_cnt == PHASE_LAST) begin
                            phase_cnt <= '0;
                            tx_q      <= 1'b0;
                            state     <= ST_BLANK;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                            tx_q      <= ~tx_q;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end

                ST_BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        blank_cnt <= '0;
                        state     <= ST_CAPTURE;
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    if (adc_valid_in) begin
                        sample_valid_out <= 1'b1;
                        sample_out       <= adc_data_in;
                        if (smp_cnt == SMP_LAST) begin
                            smp_cnt <= '0;
                            state   <= ST_WAIT;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    // A result on the expiry cycle wins over the timeout.
                    if (doppler_ready_in) begin
                        velocity_out       <= velocity_in;
                        velocity_valid_out <= 1'b1;
                        wait_cnt           <= '0;
                        state              <= ST_COOL;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_out <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= ST_COOL;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_COOL: begin
                    if (cool_cnt == COOL_LAST) begin
                        cool_cnt <= '0;
                        if (continuous_in) begin
                            state <= ST_TX;
                            tx_q  <= 1'b1;
                        end else begin
                            state    <= ST_IDLE;
                            busy_out <= 1'b0;
                        end
                    end else begin
                        cool_cnt <= cool_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    tx_q     <= 1'b0;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_doppler_ping_sequencer.sv
// Bench for doppler_ping_sequencer: directed pings with randomized data and
// timing, checked against phase-length arithmetic and an expected-value model.
module tb_doppler_ping_sequencer;

    localparam int HALF   = 10;
    localparam int TXP    = 2;
    localparam int BLANK  = 5;
    localparam int NS     = 4;
    localparam int TMO    = 20;
    localparam int COOL   = 3;
    localparam int TX_LEN = 2 * TXP * HALF;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        start_in = 1'b0;
    logic        continuous_in = 1'b0;
    logic        adc_valid_in = 1'b0;
    logic [15:0] adc_data_in = '0;
    logic        doppler_ready_in = 1'b0;
    logic [15:0] velocity_in = '0;
    logic        sample_valid_out;
    logic [15:0] sample_out;
    logic        tx_out;
    logic [15:0] velocity_out;
    logic        velocity_valid_out;
    logic        timeout_out;
    logic        busy_out;

    int errors = 0;
    int checks = 0;

    // Model state: what velocity_out and sample_out should currently hold.
    logic [15:0] exp_vel = '0;
    logic [15:0] last_sample = '0;

    doppler_ping_sequencer #(
        .CLK_FREQ(800_000),
        .EMITTED_FREQUENCY(40_000),
        .TX_PULSES(TXP),
        .BLANK_CYCLES(BLANK),
        .NUM_SAMPLES(NS),
        .RESULT_TIMEOUT(TMO),
        .COOLDOWN_CYCLES(COOL)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .start_in(start_in),
        .continuous_in(continuous_in),
        .adc_valid_in(adc_valid_in),
        .adc_data_in(adc_data_in),
        .sample_valid_out(sample_valid_out),
        .sample_out(sample_out),
        .doppler_ready_in(doppler_ready_in),
        .velocity_in(velocity_in),
        .tx_out(tx_out),
        .velocity_out(velocity_out),
        .velocity_valid_out(velocity_valid_out),
        .timeout_out(timeout_out),
        .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tx"}, 32'(tx_out), 0);
        chk({tag, "_busy"}, 32'(busy_out), 0);
        chk({tag, "_sv"}, 32'(sample_valid_out), 0);
        chk({tag, "_so"}, 32'(sample_out), 0);
        chk({tag, "_vel"}, 32'(velocity_out), 0);
        chk({tag, "_vv"}, 32'(velocity_valid_out), 0);
        chk({tag, "_to"}, 32'(timeout_out), 0);
    endtask

    // One full ping. period=0 gives random ADC strobes/data, otherwise a strobe
    // every period cycles carrying 1,2,3,... ready_off<0 or >=TMO means no result.
    task automatic ping(input bit use_start, input int period, input int ready_off,
                        input bit cont, input bit noise, input bit use_vfix,
                        input logic [15:0] vfix);
        int          acc;
        int          c;
        int          w;
        int          dn;
        bit          prev_acc;
        bit          done;
        bit          got;
        logic [15:0] new_vel;

        if (use_start) begin
            chk("idle_busy", 32'(busy_out), 0);
            start_in = 1'b1;
            tick();
            start_in = 1'b0;
        end

        for (int t = 0; t < TX_LEN; t++) begin
            chk("tx_wave", 32'(tx_out), 32'(((t / HALF) % 2) == 0));
            chk("tx_busy", 32'(busy_out), 1);
            chk("tx_vel", 32'(velocity_out), 32'(exp_vel));
            chk("tx_vv", 32'(velocity_valid_out), 0);
            start_in         = (t == 7);
            doppler_ready_in = noise && ((t % 9) == 4);
            velocity_in      = 16'($urandom);
            tick();
        end
        start_in         = 1'b0;
        doppler_ready_in = 1'b0;

        for (int b = 0; b < BLANK; b++) begin
            chk("blank_tx", 32'(tx_out), 0);
            chk("blank_sv", 32'(sample_valid_out), 0);
            chk("blank_so", 32'(sample_out), 32'(last_sample));
            adc_valid_in = 1'b1;
            adc_data_in  = 16'($urandom);
            tick();
        end

        acc = 0; c = 0; dn = 1; prev_acc = 1'b0;
        while (acc < NS && c < 400) begin
            chk("cap_sv", 32'(sample_valid_out), 32'(prev_acc));
            chk("cap_so", 32'(sample_out), 32'(last_sample));
            chk("cap_tx", 32'(tx_out), 0);
            adc_valid_in     = (period == 0) ? 1'($urandom_range(0, 1)) : ((c % period) == period - 1);
            adc_data_in      = (period == 0) ? 16'($urandom) : 16'(dn);
            doppler_ready_in = noise && 1'($urandom_range(0, 1));
            velocity_in      = 16'($urandom);
            prev_acc         = adc_valid_in;
            if (adc_valid_in) begin
                acc++;
                dn++;
                last_sample = adc_data_in;
            end
            c++;
            tick();
        end
        chk("cap_count", 32'(acc), NS);

        w = 0; done = 1'b0; got = 1'b0; new_vel = '0;
        while (!done) begin
            chk("wait_sv", 32'(sample_valid_out), (w == 0) ? 32'(prev_acc) : 0);
            chk("wait_so", 32'(sample_out), 32'(last_sample));
            chk("wait_to", 32'(timeout_out), 0);
            chk("wait_vv", 32'(velocity_valid_out), 0);
            chk("wait_vel", 32'(velocity_out), 32'(exp_vel));
            chk("wait_busy", 32'(busy_out), 1);
            adc_valid_in = (w == 0) ||
                           ((w < 6) && ((period == 0) ? 1'($urandom_range(0, 1))
                                                      : ((c % period) == period - 1)));
            adc_data_in  = (period == 0) ? 16'($urandom) : 16'(dn);
            if (adc_valid_in) dn++;
            doppler_ready_in = (w == ready_off);
            velocity_in      = use_vfix ? vfix : 16'($urandom);
            if (w == ready_off) begin
                got     = 1'b1;
                new_vel = velocity_in;
                done    = 1'b1;
            end else if (w == TMO - 1) begin
                done = 1'b1;
            end
            w++;
            c++;
            tick();
        end
        adc_valid_in = 1'b0;

        for (int k = 0; k < COOL; k++) begin
            if (k == 0 && got) exp_vel = new_vel;
            chk("cool_vv", 32'(velocity_valid_out), 32'(k == 0 && got));
            chk("cool_to", 32'(timeout_out), 32'(k == 0 && !got));
            chk("cool_vel", 32'(velocity_out), 32'(exp_vel));
            chk("cool_busy", 32'(busy_out), 1);
            chk("cool_tx", 32'(tx_out), 0);
            chk("cool_sv", 32'(sample_valid_out), 0);
            doppler_ready_in = (k == 1);
            velocity_in      = 16'($urandom);
            start_in         = (k == 1);
            continuous_in    = (k == COOL - 1) ? cont : !cont;
            tick();
        end
        doppler_ready_in = 1'b0;
        start_in         = 1'b0;

        if (!cont) begin
            chk("end_idle_busy", 32'(busy_out), 0);
            chk("end_idle_tx", 32'(tx_out), 0);
            chk("end_idle_vel", 32'(velocity_out), 32'(exp_vel));
        end
    endtask

    initial begin
        rst_in = 1'b1;
        repeat (3) tick();
        chk_reset("reset");
        rst_in = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy_out), 0);
        chk("post_rst_tx", 32'(tx_out), 0);

        // Strobes every 3rd cycle carrying 1..; result 0xFFF6 arrives in WAIT.
        ping(1'b1, 3, 4, 1'b0, 1'b0, 1'b1, 16'hFFF6);
        chk("vel_fff6", 32'(velocity_out), 32'h0000_FFF6);

        // No result: timeout, velocity keeps the previous value.
        ping(1'b1, 3, -1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("vel_held", 32'(velocity_out), 32'h0000_FFF6);

        // Result on the expiry cycle, then a continuous run of three pings.
        ping(1'b1, 0, TMO - 1, 1'b1, 1'b0, 1'b0, 16'h0000);
        ping(1'b0, 0, 7, 1'b1, 1'b1, 1'b0, 16'h0000);
        ping(1'b0, 0, -1, 1'b0, 1'b1, 1'b0, 16'h0000);

        for (int i = 0; i < 4; i++)
            ping(1'b1, 0, int'($urandom_range(0, TMO + 4)), 1'b0, 1'b1, 1'b0, 16'h0000);

        // Reset in the middle of the TX burst.
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        repeat (5) tick();
        chk("rst_tx_pre", 32'(tx_out), 1);
        rst_in = 1'b1;
        #1;
        chk("rst_tx_drop", 32'(tx_out), 0);
        tick();
        chk_reset("rst_tx");
        exp_vel = '0;
        last_sample = '0;
        rst_in = 1'b0;
        tick();

        // Load a known velocity, then reset in the middle of capture.
        ping(1'b1, 0, 1, 1'b0, 1'b0, 1'b1, 16'h1234);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        repeat (TX_LEN + BLANK) tick();
        adc_valid_in = 1'b1;
        adc_data_in  = 16'hA5A5;
        tick();
        adc_data_in  = 16'h5A5A;
        tick();
        chk("rst_cap_pre_sv", 32'(sample_valid_out), 1);
        chk("rst_cap_pre_so", 32'(sample_out), 32'h0000_5A5A);
        chk("rst_cap_pre_vel", 32'(velocity_out), 32'h0000_1234);
        adc_valid_in = 1'b0;
        rst_in = 1'b1;
        tick();
        chk_reset("rst_cap");
        exp_vel = '0;
        last_sample = '0;
        rst_in = 1'b0;
        tick();

        // Counters must restart cleanly after the reset.
        ping(1'b1, 0, 3, 1'b0, 1'b1, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
